// File: rtl/or1200_tb_wbmem.sv
// Dual-port Wishbone B3 classic slave memory for simulation benches: iwb and dwb share one
// word-addressed RAM through a round-robin arbiter with programmable wait states.
module or1200_tb_wbmem #(
  parameter int unsigned MEM_AW      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          ERR_EN      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  input  logic        iwb_we_i,
  input  logic [31:0] iwb_adr_i,
  input  logic [31:0] iwb_dat_i,
  input  logic [3:0]  iwb_sel_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  output logic        iwb_rty_o,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  input  logic        dwb_we_i,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        dwb_rty_o
);

  localparam int unsigned Depth    = 2 ** MEM_AW;
  localparam logic [33:0] WinBytes = 34'd4 << MEM_AW;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;  // 1: dwb wins the next tie
  logic        gnt_q, gnt_d;    // 1: dwb owns the current transfer
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        oow_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [Depth];

  logic              ireq, dreq, grant_dwb, gnt_cyc, commit, err_now, ack, err;
  logic [31:0]       off;
  logic [MEM_AW-1:0] idx;

  assign ireq      = iwb_cyc_i & iwb_stb_i;
  assign dreq      = dwb_cyc_i & dwb_stb_i;
  assign grant_dwb = dreq & (~ireq | prio_q);
  assign gnt_cyc   = gnt_q ? dwb_cyc_i : iwb_cyc_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ireq | dreq) begin
          gnt_d  = grant_dwb;
          prio_d = (ireq & dreq) ? ~prio_q : prio_q;
          adr_d  = grant_dwb ? dwb_adr_i : iwb_adr_i;
          wdat_d = grant_dwb ? dwb_dat_i : iwb_dat_i;
          sel_d  = grant_dwb ? dwb_sel_i : iwb_sel_i;
          we_d   = grant_dwb ? dwb_we_i : iwb_we_i;
          cnt_d  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!gnt_cyc) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decode from the transfer being committed (inputs when granting straight into RESP)
  assign off     = adr_d - BASE_ADDR;
  assign err_now = ERR_EN & ~({2'b00, off} < WinBytes);
  assign idx     = adr_d[MEM_AW+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      prio_q  <= 1'b1;
      gnt_q   <= 1'b0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      oow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      oow_q   <= err_now;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && !rst_i) begin
      rdata_q <= mem[idx];
      if (we_d && !err_now) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_d[b]) mem[idx][8*b +: 8] <= wdat_d[8*b +: 8];
        end
      end
    end
  end

  assign ack = (state_q == StResp) & ~oow_q;
  assign err = (state_q == StResp) & oow_q;

  assign iwb_ack_o = ack & ~gnt_q;
  assign iwb_err_o = err & ~gnt_q;
  assign iwb_dat_o = (ack & ~gnt_q) ? rdata_q : 32'h0;
  assign iwb_rty_o = 1'b0;
  assign dwb_ack_o = ack & gnt_q;
  assign dwb_err_o = err & gnt_q;
  assign dwb_dat_o = (ack & gnt_q) ? rdata_q : 32'h0;
  assign dwb_rty_o = 1'b0;

endmodule

// File: doc/or1200_tb_wbmem.md
Name: or1200_tb_wbmem

Overview:
Dual-port Wishbone B3 classic slave memory model that closes the instruction (iwb) and data (dwb) buses of the CPU in simulation benches.
- Both ports share one word-addressed RAM through a round-robin arbiter.
- Configurable wait states; byte-lane writes.
- Error response outside the decoded window; cycles aborted by the master are dropped cleanly.
- Replaces the tied-off ack/err inputs so fetch and load/store traffic actually completes.

Parameters:
MEM_AW, 12, log2 of memory depth in 32-bit words (depth = 2**MEM_AW)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*depth
WAIT_STATES, 1, wait cycles (0..15) inserted before ack/err
ERR_EN, 1, 1 = out-of-window access returns err; 0 = address aliases into memory and acks

Ports:
clk_i  in  1  bench clock; both buses are synchronous to it
rst_i  in  1  synchronous, active-high reset
iwb_cyc_i  in  1  instruction bus cycle
iwb_stb_i  in  1  instruction bus strobe
iwb_we_i  in  1  instruction write enable (normally 0)
iwb_adr_i  in  32  instruction byte address
iwb_dat_i  in  32  instruction write data
iwb_sel_i  in  4  instruction byte selects
iwb_dat_o  out  32  instruction read data
iwb_ack_o  out  1  instruction acknowledge
iwb_err_o  out  1  instruction error
iwb_rty_o  out  1  instruction retry, constant 0
dwb_cyc_i, dwb_stb_i, dwb_we_i, dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_dat_o, dwb_ack_o, dwb_err_o, dwb_rty_o: identical set for the data bus

Behaviour:
- Reset (rst_i sampled high at a rising edge):
  - state=IDLE; wait counter=0; round-robin pointer favours dwb.
  - All ack/err/rty outputs 0; dat_o outputs 32'h0.
  - RAM contents are not cleared.
- Request = cyc & stb on a port.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both request: grant the port the pointer favours; pointer then toggles to the other port.
  - On grant: latch port id, adr, we, sel, dat. Go to WAIT if WAIT_STATES>0, else RESP; counter loads WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; at 0 go to RESP.
  - Granted port cyc low in any WAIT cycle → abort: back to IDLE, no write, no ack/err.
- RESP:
  - Granted port's ack_o (or err_o) is high for exactly one cycle, then IDLE.
  - Write lands at the edge that enters RESP, byte lanes per sel: sel[3] → bits 31:24 … sel[0] → bits 7:0; sel=0 writes nothing but still acks.
  - Read data is registered at that edge; dat_o is valid only while ack is high, else 0.
  - cyc dropped in RESP: ack still pulses; write is already committed.
- Latency: request first sampled at edge E → ack high in the cycle after edge E+WAIT_STATES.
- Throughput: one transfer per WAIT_STATES+2 cycles. The IDLE cycle after RESP is mandatory; a master holding stb gets a new grant at that edge.
- Ungranted port: ack/err 0 and dat_o 0 throughout; it waits in its own cycle.
- Decode: word index = adr[MEM_AW+1:2]; adr[1:0] ignored.
  - In window: BASE_ADDR <= adr < BASE_ADDR+4*2**MEM_AW.
  - Out of window with ERR_EN=1: err instead of ack, same latency, no write, dat_o=0.
  - Out of window with ERR_EN=0: aliases and acks.
- rst_i mid-transaction: FSM to IDLE at that edge; any pending write is discarded; no ack/err in the following cycle.
- rty_o is always 0. cab inputs are not present; bursts run as back-to-back single cycles.

Test Plan:
- Reset: hold rst_i 3 cycles while both ports request → all ack/err/rty/dat_o 0; after release, dwb is granted first.
- WAIT_STATES=2: dwb write 32'hDEADBEEF to 0x100, sel=4'hF, then iwb read 0x100 → each ack exactly 1 cycle, 3 cycles after request sample; iwb_dat_o=32'hDEADBEEF.
- Byte lanes: write 32'h11223344 to 0x40, then write 32'hAABBCCDD with sel=4'b0010 → read 0x40 returns 32'h1122CC44.
- Arbitration, WAIT_STATES=0: both ports request continuously → ack order d,i,d,i with one IDLE cycle between acks; no cycle with both acks high.
- Window, BASE_ADDR=0, MEM_AW=12, ERR_EN=1: read 0x4000 → err pulses 1 cycle, ack 0, dat_o 0. With ERR_EN=0 → ack returns contents of word 0.
- Abort and reset: WAIT_STATES=3, dwb write to 0x8 with cyc dropped after 1 cycle → no ack, word unchanged; rst_i pulsed during WAIT of a second write → no ack, word unchanged.
